mem_port_arbiter: RTL and testbench

- Shares one single-word backing-memory port between two requesters: the instruction cache refill path (multi-word line read) and the CPU data path (word/half/byte read or write).
- Sits between the instruction cache / CPU and a unified memory model, replacing separate instruction and data memories in the pipelined system.
- Serialises one transaction at a time, issues line refills as consecutive word beats and assembles the line, and arbitrates ties round-robin or with fixed data priority.

---
 rtl/mem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-word backing-memory port between the instruction-cache
//   refill path (I side, LINE_WORDS-word line reads) and the CPU data path
//   (D side, single read or write). One transaction is in flight at a time.
//   Simultaneous requests are resolved round-robin (FAIR=1) or D-first (FAIR=0).
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_req/i_addr          I-side line request (level) and line address
//   i_qdata/i_ready       assembled line and one-cycle completion pulse
//   d_req/d_we/d_addr/
//   d_wdata/d_mode        D-side request, direction, address, data, access mode
//   d_rdata/d_ready       registered read data and one-cycle completion pulse
//   mem_valid/mem_we/
//   mem_addr/mem_wdata/
//   mem_mode              backing-memory request, held until mem_ack
//   mem_ack/mem_rdata     memory completion and read data (same cycle)

// One word of the refill line; cleared on reset so a partial line never
// survives a reset.
module lineWordReg (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module mem_port_arbiter #(
  parameter int                LINE_WORDS = 4,
  parameter int                MMD_W      = 2,
  parameter logic [MMD_W-1:0]  MODE_WORD  = '0,
  parameter int                FAIR       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [31:0]              i_addr,
  output logic [32*LINE_WORDS-1:0] i_qdata,
  output logic                     i_ready,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              d_wdata,
  input  logic [MMD_W-1:0]         d_mode,
  output logic [31:0]              d_rdata,
  output logic                     d_ready,
  output logic                     mem_valid,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [MMD_W-1:0]         mem_mode,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata
);
  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = BW + 2;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, D_ACC, I_BEAT, DONE} state_t;

  typedef struct packed {
    logic             we;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [MMD_W-1:0] mode;
  } memReq_t;

  state_t  state, stateNxt;
  memReq_t reqQ, reqNxt;
  logic    memValidQ, memValidNxt;
  logic [BW-1:0] beatQ, beatNxt;
  logic    lastGrantD, lastGrantDNxt;   // 0 = I was granted last
  logic    iReadyQ, iReadyNxt, dReadyQ, dReadyNxt;
  logic [31:0] dRdataQ, dRdataNxt;
  logic [LINE_WORDS-1:0] wordWe;
  logic [LINE_WORDS-1:0][31:0] lineQ;
  logic    grantD, grantI;
  logic    unusedBits;

  // Offset bits inside the line are ignored by design.
  assign unusedBits = ^i_addr[OFF-1:0];

  function automatic logic [31:0] lineAddr(input logic [31:0] base, input logic [BW-1:0] b);
    return {base[31:OFF], b, 2'b00};
  endfunction

  // Tie-break: D wins unless round-robin says it was served last.
  assign grantD = d_req && (!i_req || (FAIR == 0) || !lastGrantD);
  assign grantI = i_req && !grantD;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // Next-state logic
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (grantD)      stateNxt = D_ACC;
               else if (grantI) stateNxt = I_BEAT;
      D_ACC:   if (mem_ack) stateNxt = DONE;
      I_BEAT:  if (mem_ack && beatQ == LAST_BEAT) stateNxt = DONE;
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Output next values; everything leaves through registers. The memory
  // request for a grant is loaded on the grant edge so mem_valid is high in
  // the first cycle of D_ACC / I_BEAT.
  always_comb begin
    reqNxt        = reqQ;
    memValidNxt   = memValidQ;
    beatNxt       = beatQ;
    lastGrantDNxt = lastGrantD;
    iReadyNxt     = 1'b0;
    dReadyNxt     = 1'b0;
    dRdataNxt     = dRdataQ;
    wordWe        = '0;
    case (state)
      IDLE: begin
        if (grantD) begin
          memValidNxt   = 1'b1;
          reqNxt        = '{we: d_we, addr: d_addr, wdata: d_wdata, mode: d_mode};
          lastGrantDNxt = 1'b1;
        end else if (grantI) begin
          memValidNxt   = 1'b1;
          reqNxt        = '{we: 1'b0, addr: lineAddr(i_addr, '0), wdata: 32'h0, mode: MODE_WORD};
          beatNxt       = '0;
          lastGrantDNxt = 1'b0;
        end
      end
      D_ACC: begin
        if (mem_ack) begin
          memValidNxt = 1'b0;
          dReadyNxt   = 1'b1;
          if (!reqQ.we) dRdataNxt = mem_rdata;
        end
      end
      I_BEAT: begin
        if (mem_ack) begin
          wordWe[beatQ] = 1'b1;
          if (beatQ == LAST_BEAT) begin
            memValidNxt = 1'b0;
            iReadyNxt   = 1'b1;
          end else begin
            // Next beat issues straight away; back-to-back acks are legal.
            beatNxt     = beatQ + 1'b1;
            reqNxt.addr = lineAddr(i_addr, beatQ + 1'b1);
          end
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      reqQ       <= '0;
      memValidQ  <= 1'b0;
      beatQ      <= '0;
      lastGrantD <= 1'b0;
      iReadyQ    <= 1'b0;
      dReadyQ    <= 1'b0;
      dRdataQ    <= '0;
    end else begin
      reqQ       <= reqNxt;
      memValidQ  <= memValidNxt;
      beatQ      <= beatNxt;
      lastGrantD <= lastGrantDNxt;
      iReadyQ    <= iReadyNxt;
      dReadyQ    <= dReadyNxt;
      dRdataQ    <= dRdataNxt;
    end
  end

  // Line assembly: one register per word, written by its beat.
  for (genvar k = 0; k < LINE_WORDS; k++) begin : gLine
    lineWordReg uWord (
      .clk (clk),
      .rst (rst),
      .we  (wordWe[k]),
      .d   (mem_rdata),
      .q   (lineQ[k])
    );
  end

  assign i_qdata   = lineQ;
  assign i_ready   = iReadyQ;
  assign d_rdata   = dRdataQ;
  assign d_ready   = dReadyQ;
  assign mem_valid = memValidQ;
  assign mem_we    = reqQ.we;
  assign mem_addr  = reqQ.addr;
  assign mem_wdata = reqQ.wdata;
  assign mem_mode  = reqQ.mode;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A transaction-level model tracks
// which side owns the port, the expected beat addresses, the memory contents
// and the round-robin history; the bench plays both requesters and the
// memory (random wait states, stray acks while idle).
module tb_mem_port_arbiter;
  localparam int LW = 4;
  localparam int QW = 32 * LW;
  localparam int MI = 0, MB = 1, MD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, mem_ack;
  logic [31:0]   i_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]    d_mode;
  logic [QW-1:0] i_qdata;
  logic          i_ready, d_ready, mem_valid, mem_we;
  logic [31:0]   d_rdata, mem_addr, mem_wdata;
  logic [1:0]    mem_mode;

  mem_port_arbiter #(.LINE_WORDS(LW), .MMD_W(2), .MODE_WORD(2'd0), .FAIR(1)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_qdata(i_qdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mode(d_mode),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mode(mem_mode), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int nTests = 0, nFail = 0;

  task automatic chk(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Backing memory: written words are remembered, others read a fixed pattern.
  logic [31:0] memA [logic [29:0]];
  function automatic logic [31:0] rd(input logic [31:0] a);
    if (memA.exists(a[31:2])) return memA[a[31:2]];
    return {a[17:2] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic int newWait();
    return ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 3));
  endfunction

  // Model state
  int          mState = MI, beat = 0, waitCnt = 0, waitTgt = 0;
  bit          sideD = 0, lastD = 0, dAct = 0, iAct = 0, postReset = 0, rstDone = 0;
  bit          wasIdle, dropD, dropI;
  logic        dWeOp;
  logic [31:0] dAddrOp, dWdataOp, iAddrOp, expAddr;
  logic [1:0]  dModeOp, b2;
  logic [31:0] dRdataM = '0;
  logic [QW-1:0] lineM = '0, lineP = '0;
  int nD = 0, nI = 0;

  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_mode = 0; mem_rdata = 0;
    dWeOp = 0; dAddrOp = 0; dWdataOp = 0; dModeOp = 0; iAddrOp = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    postReset = 1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      // Cycle-level checks of the current outputs against the model
      chk("memValid", QW'(mem_valid), QW'(mState == MB));
      chk("dReady", QW'(d_ready), QW'(mState == MD && sideD));
      chk("iReady", QW'(i_ready), QW'(mState == MD && !sideD));
      chk("dRdata", QW'(d_rdata), QW'(dRdataM));
      if (!(mState == MB && !sideD)) chk("iQdata", i_qdata, lineM);
      if (postReset) begin
        chk("rstMemAddr", QW'(mem_addr), '0);
        chk("rstMemWe", QW'(mem_we), '0);
        chk("rstMemWdata", QW'(mem_wdata), '0);
        chk("rstMemMode", QW'(mem_mode), '0);
        postReset = 0;
      end

      // Reset in the middle of a refill, on beat 2
      if (!rstDone && cyc > 300 && mState == MB && !sideD && beat == 2) begin
        rstDone = 1; rst = 1'b1; mem_ack = 1'b0;
        mState = MI; lastD = 0; dRdataM = '0; lineM = '0;
        postReset = 1;
        continue;
      end

      wasIdle = (mState == MI);
      dropD = 0; dropI = 0;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      case (mState)
        MB: begin
          if (sideD) begin
            chk("dMemAddr", QW'(mem_addr), QW'(dAddrOp));
            chk("dMemWe", QW'(mem_we), QW'(dWeOp));
            chk("dMemWdata", QW'(mem_wdata), QW'(dWdataOp));
            chk("dMemMode", QW'(mem_mode), QW'(dModeOp));
          end else begin
            b2 = beat[1:0];
            expAddr = {iAddrOp[31:4], b2, 2'b00};
            chk("iMemAddr", QW'(mem_addr), QW'(expAddr));
            chk("iMemWe", QW'(mem_we), '0);
            chk("iMemMode", QW'(mem_mode), '0);
          end
          if (waitCnt >= waitTgt) begin
            mem_ack = 1'b1;
            waitCnt = 0; waitTgt = newWait();
            if (sideD) begin
              if (dWeOp) memA[dAddrOp[31:2]] = dWdataOp;
              else begin mem_rdata = rd(dAddrOp); dRdataM = mem_rdata; end
              mState = MD;
            end else begin
              mem_rdata = rd(expAddr);
              lineP[32*beat +: 32] = mem_rdata;
              beat++;
              if (beat == LW) begin lineM = lineP; mState = MD; end
            end
          end else waitCnt++;
        end
        MD: begin
          mem_ack = ($urandom % 4 == 0);   // stray ack, must be ignored
          if (sideD) begin dAct = 0; dropD = 1; nD++; end
          else       begin iAct = 0; dropI = 1; nI++; end
          mState = MI;
        end
        default: mem_ack = ($urandom % 4 == 0);
      endcase

      // Requesters
      if (!dAct && !dropD && $urandom % 3 == 0) begin
        dAct = 1; dWeOp = $urandom % 2; dAddrOp = $urandom_range(0, 1023);
        dWdataOp = $urandom; dModeOp = $urandom % 3;
      end
      if (!iAct && !dropI && $urandom % 3 == 0) begin
        iAct = 1; iAddrOp = $urandom_range(0, 1023);
      end

      // Arbitration: only requests seen in an idle cycle are granted
      if (wasIdle && (dAct || iAct)) begin
        sideD = dAct && (!iAct || !lastD);
        lastD = sideD;
        mState = MB; beat = 0; waitCnt = 0; waitTgt = newWait();
        lineP = lineM;
      end

      d_req = dAct; d_we = dWeOp; d_addr = dAddrOp; d_wdata = dWdataOp; d_mode = dModeOp;
      i_req = iAct; i_addr = iAddrOp;
    end

    chk("sawResetMidRefill", QW'(rstDone), QW'(1));
    chk("someDDone", QW'(nD > 10), QW'(1));
    chk("someIDone", QW'(nI > 10), QW'(1));
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
